// File: rtl/pc_next_unit.sv
// pc_next_unit
// Program-counter stage of the single-cycle CPU. Holds the PC register, selects the
// next PC from sequential / branch / jump / jump-register sources, runs a RUN/HALT
// state machine and keeps two statistics counters.
//
// Ports:
//   in_clk             clock, all state updates on rising edge
//   in_rst             synchronous active-high reset
//   in_extended        32-bit extended immediate (branch offset in words)
//   in_instr_index     J/JAL target field instr[25:0]
//   in_jr_target       register value for JR
//   in_branch_taken    branch with condition true
//   in_jump            J or JAL
//   in_jr              JR
//   in_halt            halt instruction in current cycle
//   in_go              resume request while halted
//   out_pc             current PC (registered)
//   out_pc_plus4       out_pc + 4 (combinational, JAL link value)
//   out_halted         1 while in HALT (registered)
//   out_cycle_count    edges spent in RUN
//   out_transfer_count taken branches / jumps / JRs

module pc_next_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   in_clk,
   input  logic                   in_rst,
   input  logic [31:0]            in_extended,
   input  logic [25:0]            in_instr_index,
   input  logic [31:0]            in_jr_target,
   input  logic                   in_branch_taken,
   input  logic                   in_jump,
   input  logic                   in_jr,
   input  logic                   in_halt,
   input  logic                   in_go,
   output logic [31:0]            out_pc,
   output logic [31:0]            out_pc_plus4,
   output logic                   out_halted,
   output logic [COUNT_WIDTH-1:0] out_cycle_count,
   output logic [COUNT_WIDTH-1:0] out_transfer_count
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

   state_e                 state_q;
   logic [31:0]            pc_q;
   logic                   halted_q;
   logic [COUNT_WIDTH-1:0] cycle_count_q;
   logic [COUNT_WIDTH-1:0] transfer_count_q;

   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;

   // Candidate targets; all arithmetic wraps modulo 2^32.
   always_comb begin
      pc_plus4      = pc_q + 32'd4;
      branch_target = pc_plus4 + {in_extended[29:0], 2'b00};
      jump_target   = {pc_plus4[31:28], in_instr_index, 2'b00};
      jr_target     = {in_jr_target[31:2], 2'b00};
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q          <= StRun;
         pc_q             <= RESET_PC;
         halted_q         <= 1'b0;
         cycle_count_q    <= '0;
         transfer_count_q <= '0;
      end else begin
         unique case (state_q)
            StRun: begin
               // The edge entering HALT still counts as a RUN cycle.
               cycle_count_q <= cycle_count_q + CountOne;
               if (in_halt) begin
                  // Halt masks any simultaneous transfer; PC holds on the halt insn.
                  state_q  <= StHalt;
                  halted_q <= 1'b1;
               end else if (in_jr) begin
                  pc_q             <= jr_target;
                  transfer_count_q <= transfer_count_q + CountOne;
               end else if (in_jump) begin
                  pc_q             <= jump_target;
                  transfer_count_q <= transfer_count_q + CountOne;
               end else if (in_branch_taken) begin
                  pc_q             <= branch_target;
                  transfer_count_q <= transfer_count_q + CountOne;
               end else begin
                  pc_q <= pc_plus4;
               end
            end
            StHalt: begin
               // Resume retires the halt instruction by stepping past it.
               if (in_go) begin
                  state_q  <= StRun;
                  halted_q <= 1'b0;
                  pc_q     <= pc_plus4;
               end
            end
            default: begin
               state_q  <= StRun;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_pc             = pc_q;
   assign out_pc_plus4       = pc_plus4;
   assign out_halted         = halted_q;
   assign out_cycle_count    = cycle_count_q;
   assign out_transfer_count = transfer_count_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

   logic        clk;
   logic        rst;
   logic [31:0] extended;
   logic [25:0] instr_index;
   logic [31:0] jr_target;
   logic        branch_taken, jump, jr, halt, go;

   logic [31:0] pc, pc_plus4;
   logic        halted;
   logic [31:0] cyc, xfer;

   logic [31:0] pc_n, pc_plus4_n;
   logic        halted_n;
   logic [3:0]  cyc_n, xfer_n;

   int errors = 0;
   int checks = 0;

   pc_next_unit #(.RESET_PC(32'h0000_3000), .COUNT_WIDTH(32)) dut (
      .in_clk(clk), .in_rst(rst), .in_extended(extended), .in_instr_index(instr_index),
      .in_jr_target(jr_target), .in_branch_taken(branch_taken), .in_jump(jump), .in_jr(jr),
      .in_halt(halt), .in_go(go), .out_pc(pc), .out_pc_plus4(pc_plus4),
      .out_halted(halted), .out_cycle_count(cyc), .out_transfer_count(xfer)
   );

   // Narrow-counter instance sharing the same stimulus, for counter wrap checks.
   pc_next_unit #(.RESET_PC(32'h0000_3000), .COUNT_WIDTH(4)) dut_n (
      .in_clk(clk), .in_rst(rst), .in_extended(extended), .in_instr_index(instr_index),
      .in_jr_target(jr_target), .in_branch_taken(branch_taken), .in_jump(jump), .in_jr(jr),
      .in_halt(halt), .in_go(go), .out_pc(pc_n), .out_pc_plus4(pc_plus4_n),
      .out_halted(halted_n), .out_cycle_count(cyc_n), .out_transfer_count(xfer_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (got running, want done)");
      $fatal(1);
   end

   typedef struct {
      logic        rst;
      logic [31:0] ext;
      logic [25:0] idx;
      logic [31:0] jrt;
      logic        br, j, jrs, hlt, go;
      logic [31:0] pc;
      logic        h;
      logic [31:0] cyc;
      logic [31:0] xfer;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(logic r, logic [31:0] e, logic [25:0] ix, logic [31:0] jt,
                               logic b, logic jp, logic js, logic hl, logic g,
                               logic [31:0] p, logic hh, logic [31:0] c, logic [31:0] x);
      vec_t t;
      t.rst = r; t.ext = e; t.idx = ix; t.jrt = jt; t.br = b; t.j = jp; t.jrs = js;
      t.hlt = hl; t.go = g; t.pc = p; t.h = hh; t.cyc = c; t.xfer = x;
      return t;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Drive one vector, queue its expectation, then compare once the edge has passed.
   task automatic step(vec_t t);
      vec_t e;
      @(negedge clk);
      rst = t.rst; extended = t.ext; instr_index = t.idx; jr_target = t.jrt;
      branch_taken = t.br; jump = t.j; jr = t.jrs; halt = t.hlt; go = t.go;
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("pc", pc, e.pc);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
      check("halted", {31'd0, halted}, {31'd0, e.h});
      check("cycle_count", cyc, e.cyc);
      check("transfer_count", xfer, e.xfer);
      check("narrow_pc", pc_n, e.pc);
      check("narrow_cycle_count", {28'd0, cyc_n}, {28'd0, e.cyc[3:0]});
      check("narrow_transfer_count", {28'd0, xfer_n}, {28'd0, e.xfer[3:0]});
   endtask

   initial begin
      rst = 1'b1; extended = '0; instr_index = '0; jr_target = '0;
      branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; halt = 1'b0; go = 1'b0;

      //               rst ext           idx       jrt           br j  jr hl go  pc            h  cyc xfer
      vecs.push_back(mk(1, 32'h0,        26'h0,    32'h0,        0, 0, 0, 0, 0, 32'h0000_3000, 0, 0,  0));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0,        0, 0, 0, 0, 0, 32'h0000_3004, 0, 1,  0));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0,        0, 0, 0, 0, 0, 32'h0000_3008, 0, 2,  0));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0,        0, 0, 0, 0, 1, 32'h0000_300C, 0, 3,  0));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0000_0100, 0, 0, 1, 0, 0, 32'h0000_0100, 0, 4,  1));
      vecs.push_back(mk(0, 32'hFFFF_FFFE, 26'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0000_00FC, 0, 5,  2));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0000_0100, 0, 0, 1, 0, 0, 32'h0000_0100, 0, 6,  3));
      vecs.push_back(mk(0, 32'h0000_0003, 26'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0000_0110, 0, 7,  4));
      vecs.push_back(mk(0, 32'hFFFF_FFFF, 26'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0000_0110, 0, 8,  5));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h4000_0010, 0, 0, 1, 0, 0, 32'h4000_0010, 0, 9,  6));
      vecs.push_back(mk(0, 32'h0,        26'h40,   32'h0,        0, 1, 0, 0, 0, 32'h4000_0100, 0, 10, 7));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h4000_0010, 0, 0, 1, 0, 0, 32'h4000_0010, 0, 11, 8));
      vecs.push_back(mk(0, 32'h0000_0010, 26'h40,  32'h1234_5677, 1, 1, 1, 0, 0, 32'h1234_5674, 0, 12, 9));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0000_0200, 0, 0, 1, 0, 0, 32'h0000_0200, 0, 13, 10));
      vecs.push_back(mk(0, 32'h0,        26'h40,   32'h0,        0, 1, 0, 1, 0, 32'h0000_0200, 1, 14, 10));
      // Held in HALT: every control except in_go ignored, counters frozen.
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 32'h4, 26'h40, 32'h0000_0500, 1, 1, 1, 1, 0,
                           32'h0000_0200, 1, 14, 10));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0000_0500, 0, 0, 1, 0, 1, 32'h0000_0204, 0, 14, 10));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0,        0, 0, 0, 0, 1, 32'h0000_0208, 0, 15, 10));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0,        0, 0, 0, 1, 0, 32'h0000_0208, 1, 16, 10));
      vecs.push_back(mk(1, 32'h0,        26'h0,    32'h0,        0, 0, 0, 1, 0, 32'h0000_3000, 0, 0,  0));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'hFFFF_FFFF, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 1,  1));
      vecs.push_back(mk(0, 32'h0,        26'h0,    32'h0,        0, 0, 0, 0, 0, 32'h0000_0000, 0, 2,  1));
      vecs.push_back(mk(1, 32'h0,        26'h0,    32'h0000_0700, 0, 0, 1, 0, 0, 32'h0000_3000, 0, 0,  0));

      foreach (vecs[i]) step(vecs[i]);

      // Counter wrap on the 4-bit instance: 15 RUN cycles reach all-ones, one more wraps.
      for (int i = 1; i <= 16; i++) begin
         step(mk(0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 0, 0,
                 32'h0000_3000 + 32'(4 * i), 0, 32'(i), 0));
         if (i == 15) check("narrow_count_all_ones", {28'd0, cyc_n}, 32'd15);
         if (i == 16) check("narrow_count_wrapped", {28'd0, cyc_n}, 32'd0);
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
